// File: rtl/core_scheduler.sv
// core_scheduler: central work scheduler for the processor array.
// Holds a 16-entry kernel start-PC table and a FIFO of queue numbers.
// Per-core pending slots feed the FIFO. Waiting cores are handed
// table[head] one at a time in round-robin order.
module core_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int PC_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_queue_wen,
    input  logic [4*NUM_CORES-1:0]        core_queue_number,
    input  logic                          tbl_wen,
    input  logic [3:0]                    tbl_waddr,
    input  logic [PC_W-1:0]               tbl_wval,
    input  logic                          start,
    output logic [PC_W*NUM_CORES-1:0]     core_new_pc,
    output logic [2*NUM_CORES-1:0]        core_idle,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          done,
    output logic                          overflow
);

    localparam int CW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    // Encodings double as the core_idle code driven to each core
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } core_state_e;

    core_state_e           state_q [NUM_CORES];
    core_state_e           state_d [NUM_CORES];
    logic [PC_W-1:0]       pc_q [NUM_CORES];
    logic [PC_W-1:0]       pc_d [NUM_CORES];
    logic [PC_W-1:0]       table_q [16];
    logic [PC_W-1:0]       table_d [16];
    logic [3:0]            fifo_q [FIFO_DEPTH];
    logic [3:0]            fifo_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]       count_q, count_d;
    logic [NUM_CORES-1:0]  slot_valid_q, slot_valid_d;
    logic [3:0]            slot_num_q [NUM_CORES];
    logic [3:0]            slot_num_d [NUM_CORES];
    logic [CW-1:0]         rr_disp_q, rr_disp_d;
    logic [CW-1:0]         rr_push_q, rr_push_d;
    logic                  started_q, started_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;

    logic                  fifo_empty, fifo_full;
    logic [3:0]            head_num;
    logic [PC_W-1:0]       head_pc;
    logic [NUM_CORES-1:0]  wait_vec;
    logic [CW:0]           grant_pick, drain_pick;
    logic                  grant_valid, drain_valid;
    logic [CW-1:0]         grant_idx, drain_idx;
    logic [NUM_CORES-1:0]  grant, drain, drop;
    logic                  push_en;
    logic [3:0]            push_num;
    logic                  halt_cond;

    // First requester at or after ptr, wrapping; returns {found, index}
    function automatic logic [CW:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                            input logic [CW-1:0] ptr);
        logic [CW:0]   res;
        logic [CW-1:0] idx;
        res = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = CW'((int'(ptr) + k) % NUM_CORES);
            if (!res[CW] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] i);
        return (i == CW'(NUM_CORES - 1)) ? '0 : i + 1'b1;
    endfunction

    // State register: every flop, cleared by asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                state_q[i]    <= ST_WAIT;
                pc_q[i]       <= '0;
                slot_num_q[i] <= '0;
            end
            for (int j = 0; j < 16; j++) begin
                table_q[j] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                fifo_q[j] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            slot_valid_q <= '0;
            rr_disp_q    <= '0;
            rr_push_q    <= '0;
            started_q    <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                state_q[i]    <= state_d[i];
                pc_q[i]       <= pc_d[i];
                slot_num_q[i] <= slot_num_d[i];
            end
            for (int j = 0; j < 16; j++) begin
                table_q[j] <= table_d[j];
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                fifo_q[j] <= fifo_d[j];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            slot_valid_q <= slot_valid_d;
            rr_disp_q    <= rr_disp_d;
            rr_push_q    <= rr_push_d;
            started_q    <= started_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Arbitration: one dispatch grant and one slot drain per cycle, start owns the write port
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNTW'(FIFO_DEPTH));
        head_num   = fifo_q[rd_ptr_q];
        head_pc    = table_q[head_num];
        for (int i = 0; i < NUM_CORES; i++) begin
            wait_vec[i] = (state_q[i] == ST_WAIT);
        end
        grant_pick  = rr_pick(fifo_empty ? '0 : wait_vec, rr_disp_q);
        grant_valid = grant_pick[CW];
        grant_idx   = grant_pick[CW-1:0];
        grant       = '0;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
        drain_pick  = rr_pick((fifo_full || start) ? '0 : slot_valid_q, rr_push_q);
        drain_valid = drain_pick[CW];
        drain_idx   = drain_pick[CW-1:0];
        drain       = '0;
        if (drain_valid) begin
            drain[drain_idx] = 1'b1;
        end
        push_en   = start ? !fifo_full : drain_valid;
        push_num  = start ? 4'd0 : slot_num_q[drain_idx];
        halt_cond = started_q && (&wait_vec) && fifo_empty && !(|slot_valid_q)
                    && !start && !(|core_queue_wen);
    end

    // FIFO and kernel table next state; the table write lands after this cycle's lookup
    always_comb begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            fifo_d[j] = fifo_q[j];
        end
        for (int j = 0; j < 16; j++) begin
            table_d[j] = table_q[j];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            fifo_d[wr_ptr_q] = push_num;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (grant_valid) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{(CNTW-1){1'b0}}, push_en} - {{(CNTW-1){1'b0}}, grant_valid};
        if (tbl_wen) begin
            table_d[tbl_waddr] = tbl_wval;
        end
    end

    // Pending slots: a push into a slot that stays occupied is lost and flagged
    always_comb begin
        drop = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            slot_valid_d[i] = slot_valid_q[i] & ~drain[i];
            slot_num_d[i]   = slot_num_q[i];
            if (core_queue_wen[i]) begin
                if (slot_valid_q[i] && !drain[i]) begin
                    drop[i] = 1'b1;
                end else begin
                    slot_valid_d[i] = 1'b1;
                    slot_num_d[i]   = core_queue_number[4*i +: 4];
                end
            end
        end
        rr_push_d  = drain_valid ? next_idx(drain_idx) : rr_push_q;
        overflow_d = overflow_q | (start & fifo_full) | (|drop);
    end

    // Per-core FSM next state plus the global started/done/rr_disp bookkeeping
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            state_d[i] = state_q[i];
            pc_d[i]    = pc_q[i];
            case (state_q[i])
                ST_RUN: begin
                    if (core_req[i]) begin
                        state_d[i] = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (grant[i]) begin
                        state_d[i] = ST_RUN;
                        pc_d[i]    = head_pc;
                    end else if (halt_cond) begin
                        state_d[i] = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (!fifo_empty || start) begin
                        state_d[i] = ST_WAIT;
                    end
                end
                default: state_d[i] = ST_WAIT;
            endcase
        end
        rr_disp_d = grant_valid ? next_idx(grant_idx) : rr_disp_q;
        started_d = started_q | start;
        if (start) begin
            done_d = 1'b0;
        end else if (halt_cond) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end
    end

    // Outputs straight from registered state
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            core_idle[2*i +: 2]      = state_q[i];
            core_new_pc[PC_W*i +: PC_W] = pc_q[i];
        end
        fifo_count = count_q;
        done       = done_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_core_scheduler.sv
// tb_core_scheduler: directed bench for core_scheduler (4 cores, depth 8, 16-bit PC).
// Expected dispatches go into a scoreboard queue when the work is pushed and
// are popped whenever a core is seen moving from WAIT to RUN.
module tb_core_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  core_req;
    logic [3:0]  core_queue_wen;
    logic [15:0] core_queue_number;
    logic        tbl_wen;
    logic [3:0]  tbl_waddr;
    logic [15:0] tbl_wval;
    logic        start;
    logic [63:0] core_new_pc;
    logic [7:0]  core_idle;
    logic [3:0]  fifo_count;
    logic        done;
    logic        overflow;

    typedef struct {
        int          core;
        logic [15:0] pc;
    } disp_t;

    disp_t      sb[$];
    logic [1:0] prev_idle [4];
    int         checks = 0;
    int         errors = 0;

    core_scheduler #(
        .NUM_CORES (4),
        .FIFO_DEPTH(8),
        .PC_W      (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .core_req         (core_req),
        .core_queue_wen   (core_queue_wen),
        .core_queue_number(core_queue_number),
        .tbl_wen          (tbl_wen),
        .tbl_waddr        (tbl_waddr),
        .tbl_wval         (tbl_wval),
        .start            (start),
        .core_new_pc      (core_new_pc),
        .core_idle        (core_idle),
        .fifo_count       (fifo_count),
        .done             (done),
        .overflow         (overflow)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expectDispatch(input int core, input logic [15:0] pc);
        disp_t e;
        e.core = core;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    // A WAIT->RUN transition is a dispatch; it must match the scoreboard head
    task automatic scanDispatch();
        logic [1:0] cur;
        disp_t      e;
        for (int i = 0; i < 4; i++) begin
            cur = core_idle[2*i +: 2];
            if (prev_idle[i] == 2'd1 && cur == 2'd0) begin
                checkOutput("dispatch_expected", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput("dispatch_core", 64'(i), 64'(e.core));
                    checkOutput("dispatch_pc", 64'(core_new_pc[16*i +: 16]), 64'(e.pc));
                end
            end
            prev_idle[i] = cur;
        end
    endtask

    // Drive one cycle of inputs, sample just after the edge, then return inputs to idle
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] wen,
                                 input logic [15:0] qnum, input logic st);
        core_req          = req;
        core_queue_wen    = wen;
        core_queue_number = qnum;
        start             = st;
        @(posedge clk);
        #1;
        scanDispatch();
        core_req          = '0;
        core_queue_wen    = '0;
        core_queue_number = '0;
        start             = 1'b0;
        tbl_wen           = 1'b0;
    endtask

    task automatic writeTable(input logic [3:0] addr, input logic [15:0] val);
        tbl_wen   = 1'b1;
        tbl_waddr = addr;
        tbl_wval  = val;
        applyStimulus(4'h0, 4'h0, 16'h0, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'h0, 4'h0, 16'h0, 1'b0);
        applyStimulus(4'h0, 4'h0, 16'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(4'h0, 4'h0, 16'h0, 1'b0);
        end
    endtask

    // Directed sequence
    initial begin
        rst               = 1'b1;
        core_req          = '0;
        core_queue_wen    = '0;
        core_queue_number = '0;
        tbl_wen           = 1'b0;
        tbl_waddr         = '0;
        tbl_wval          = '0;
        start             = 1'b0;
        for (int i = 0; i < 4; i++) prev_idle[i] = 2'd1;

        // Reset state
        doReset();
        checkOutput("reset_idle", 64'(core_idle), 64'h55);
        checkOutput("reset_pc", core_new_pc, 64'h0);
        checkOutput("reset_count", 64'(fifo_count), 64'h0);
        checkOutput("reset_done", 64'(done), 64'h0);
        checkOutput("reset_overflow", 64'(overflow), 64'h0);

        writeTable(4'd1, 16'h1111);
        writeTable(4'd2, 16'h2222);
        writeTable(4'd3, 16'h0100);
        writeTable(4'd4, 16'h4444);

        // Round-robin: four number-3 entries go to cores 0..3 back to back
        for (int i = 0; i < 4; i++) expectDispatch(i, 16'h0100);
        applyStimulus(4'h0, 4'hF, 16'h3333, 1'b0);
        idleCycles(2);
        checkOutput("rr_idle_after_first", 64'(core_idle), 64'h54);
        idleCycles(4);
        checkOutput("rr_sb_drained", 64'(sb.size()), 64'h0);
        checkOutput("rr_count", 64'(fifo_count), 64'h0);

        // Simultaneous pushes with all cores running: FIFO fills 1,2,3,4 in order
        writeTable(4'd3, 16'h3333);
        applyStimulus(4'h0, 4'hF, 16'h4321, 1'b0);
        checkOutput("simul_count_0", 64'(fifo_count), 64'h0);
        for (int k = 1; k <= 4; k++) begin
            idleCycles(1);
            checkOutput($sformatf("simul_count_%0d", k), 64'(fifo_count), 64'(k));
        end
        checkOutput("simul_overflow", 64'(overflow), 64'h0);
        expectDispatch(0, 16'h1111);
        expectDispatch(1, 16'h2222);
        expectDispatch(2, 16'h3333);
        expectDispatch(3, 16'h4444);
        applyStimulus(4'hF, 4'h0, 16'h0, 1'b0);
        idleCycles(5);
        checkOutput("simul_sb_drained", 64'(sb.size()), 64'h0);

        // Overflow: fill FIFO to 8 with cores running, then double-push on cores 0 and 1
        for (int k = 0; k < 8; k++) applyStimulus(4'h0, 4'h1, 16'h0001, 1'b0);
        idleCycles(1);
        checkOutput("full_count", 64'(fifo_count), 64'h8);
        checkOutput("full_overflow", 64'(overflow), 64'h0);
        applyStimulus(4'h0, 4'h3, 16'h0022, 1'b0);
        checkOutput("ovf_first_push", 64'(overflow), 64'h0);
        applyStimulus(4'h0, 4'h3, 16'h0022, 1'b0);
        checkOutput("ovf_set", 64'(overflow), 64'h1);
        checkOutput("ovf_count", 64'(fifo_count), 64'h8);
        idleCycles(1);
        checkOutput("ovf_sticky", 64'(overflow), 64'h1);
        // Drain the full FIFO plus both pending slots with every core requesting
        for (int k = 0; k < 8; k++) expectDispatch(k % 4, 16'h1111);
        expectDispatch(0, 16'h2222);
        expectDispatch(1, 16'h2222);
        for (int k = 0; k < 14; k++) applyStimulus(4'hF, 4'h0, 16'h0, 1'b0);
        idleCycles(1);
        checkOutput("drain_sb_empty", 64'(sb.size()), 64'h0);
        checkOutput("drain_count", 64'(fifo_count), 64'h0);
        checkOutput("drain_overflow_sticky", 64'(overflow), 64'h1);

        // Launch after reset
        doReset();
        checkOutput("reset2_overflow", 64'(overflow), 64'h0);
        writeTable(4'd0, 16'h0040);
        expectDispatch(0, 16'h0040);
        applyStimulus(4'h0, 4'h0, 16'h0, 1'b1);
        checkOutput("launch_count_1", 64'(fifo_count), 64'h1);
        idleCycles(1);
        checkOutput("launch_idle_core1", 64'(core_idle[3:2]), 64'h1);
        checkOutput("launch_pc", core_new_pc, 64'h0000_0000_0000_0040);
        checkOutput("launch_count_0", 64'(fifo_count), 64'h0);

        // Halt once everything is waiting, then restart
        applyStimulus(4'hF, 4'h0, 16'h0, 1'b0);
        checkOutput("prehalt_done", 64'(done), 64'h0);
        idleCycles(1);
        checkOutput("halt_idle", 64'(core_idle), 64'hAA);
        checkOutput("halt_done", 64'(done), 64'h1);
        expectDispatch(1, 16'h0040);
        applyStimulus(4'h0, 4'h0, 16'h0, 1'b1);
        checkOutput("restart_done", 64'(done), 64'h0);
        checkOutput("restart_idle", 64'(core_idle), 64'h55);
        idleCycles(1);
        checkOutput("restart_pc", core_new_pc, 64'h0000_0000_0040_0040);
        checkOutput("restart_sb_empty", 64'(sb.size()), 64'h0);

        // Async reset while a grant is pending
        applyStimulus(4'h0, 4'h1, 16'h0000, 1'b0);
        applyStimulus(4'h0, 4'h1, 16'h0000, 1'b1);
        checkOutput("pre_arst_overflow", 64'(overflow), 64'h1);
        checkOutput("pre_arst_count", 64'(fifo_count), 64'h1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_idle", 64'(core_idle), 64'h55);
        checkOutput("arst_pc", core_new_pc, 64'h0);
        checkOutput("arst_count", 64'(fifo_count), 64'h0);
        checkOutput("arst_overflow", 64'(overflow), 64'h0);
        checkOutput("arst_done", 64'(done), 64'h0);
        idleCycles(1);
        rst = 1'b0;
        idleCycles(2);
        checkOutput("post_arst_idle", 64'(core_idle), 64'h55);
        checkOutput("post_arst_count", 64'(fifo_count), 64'h0);
        checkOutput("final_sb_empty", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
